// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Load strobe, data word and serial line status of the frame transmitter.
interface serial_frame_tx_if #(
    parameter int unsigned WIDTH = 4
);

    logic             enable;
    logic [WIDTH-1:0] data_in;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output enable,
        output data_in,
        input  serial_out,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  data_in,
        output serial_out,
        output busy,
        output done
    );

endinterface

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit period timer: counts while run is high and ticks on the last cycle of each period.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = run && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || !run || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit, data LSB-first, optional even parity, stop bit.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    serial_frame_tx_if.slave  bus
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             par_q, par_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             accept;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .reset(reset),
        .run  (state_q != IDLE),
        .tick (tick)
    );

    assign accept = (state_q == IDLE) && bus.enable;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every non-idle state advances only on a bit period tick
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.enable) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && (idx_q == IDX_LAST)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values, derived from the upcoming state so the outputs can be registered
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        if (accept) begin
            shift_d = bus.data_in;
            par_d   = ^bus.data_in;
        end else if ((state_q == DATA) && tick) begin
            shift_d = shift_q >> 1;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        so_d = IDLE_LEVEL;
        unique case (state_d)
            IDLE:    so_d = IDLE_LEVEL;
            START:   so_d = START_BIT;
            DATA:    so_d = shift_d[0];
            PARITY:  so_d = par_d;
            STOP:    so_d = STOP_BIT;
            default: so_d = IDLE_LEVEL;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    // Output and datapath registers; a reset mid-frame drops the frame without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            so_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.serial_out = so_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
